// File: rtl/chu_vga_note_lane_core.sv
// Four-lane falling-note overlay for the VGA daisy chain: per-lane age-ordered
// note queues advanced once per frame, with hit/miss scoring and a registered pixel mux.
module chu_vga_note_lane_core #(
  parameter int CD      = 12,
  parameter int NOTE_H  = 16,
  parameter int HIT_Y   = 420,
  parameter int HIT_WIN = 16,
  parameter int LANE_X0 = 160,
  parameter int LANE_W  = 80,
  parameter logic [CD-1:0] COLOR0 = 12'hf00,
  parameter logic [CD-1:0] COLOR1 = 12'h0f0,
  parameter logic [CD-1:0] COLOR2 = 12'h00f,
  parameter logic [CD-1:0] COLOR3 = 12'hff0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);

  typedef enum logic [1:0] {IDLE, ADVANCE, RETIRE} state_t;

  localparam logic [8:0]  HIT_LO = 9'(HIT_Y - HIT_WIN);
  localparam logic [8:0]  HIT_HI = 9'(HIT_Y + HIT_WIN);
  localparam logic [8:0]  BOTTOM = 9'd480;
  localparam logic [10:0] LINE_Y = 11'(HIT_Y + NOTE_H / 2);
  localparam logic [10:0] LINE_XL = 11'(LANE_X0);
  localparam logic [10:0] LINE_XH = 11'(LANE_X0 + 4 * LANE_W);
  localparam logic [CD-1:0] COLORS [4] = '{COLOR0, COLOR1, COLOR2, COLOR3};

  state_t        state_q, state_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic          pend_v_q, pend_v_d, pend_hit_q, pend_hit_d;
  logic [1:0]    pend_lane_q, pend_lane_d;
  logic [15:0]   hit_q, hit_d, miss_q, miss_d;
  logic [8:0]    mem_q [4][8];
  logic [8:0]    mem_d [4][8];
  logic [2:0]    head_q [4], head_d [4], tail_q [4], tail_d [4];
  logic [3:0]    cnt_q [4], cnt_d [4];
  logic          origin_q, frame_tick;
  logic [CD-1:0] so_rgb_q, so_rgb_d;

  logic          wr_en, op_v, op_hit, note_hit, on_line;
  logic [1:0]    op_lane;
  logic [5:0]    miss_add;
  logic [16:0]   miss_sum;
  logic [CD-1:0] note_col;
  logic          unused_bits;

  assign unused_bits = ^{addr[13:2], wr_data[31:8]};
  assign wr_en       = cs & write;
  assign frame_tick  = (x == 11'd0) && (y == 11'd0) && !origin_q;

  // Slot e of a lane is live when it lies within count entries of head.
  function automatic logic is_active(input logic [2:0] idx, input logic [2:0] hd,
                                     input logic [3:0] cnt);
    logic [2:0] rel;
    rel = idx - hd;
    return {1'b0, rel} < cnt;
  endfunction

  function automatic logic [8:0] sat_add(input logic [8:0] v, input logic [3:0] s);
    logic [9:0] sum;
    sum = {1'b0, v} + {6'd0, s};
    return sum[9] ? 9'd511 : sum[8:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    pend_v_d    = pend_v_q;
    pend_hit_d  = pend_hit_q;
    pend_lane_d = pend_lane_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    op_v        = 1'b0;
    op_hit      = 1'b0;
    op_lane     = 2'd0;
    miss_add    = 6'd0;
    miss_sum    = 17'd0;

    if (wr_en && addr[1:0] == 2'd0) ctrl_d = wr_data[7:0];

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          op_v     = 1'b1;
          op_hit   = pend_hit_q;
          op_lane  = pend_lane_q;
          pend_v_d = 1'b0;
        end else if (wr_en && (addr[1:0] == 2'd1 || addr[1:0] == 2'd2)) begin
          op_v    = 1'b1;
          op_hit  = addr[1];
          op_lane = wr_data[1:0];
        end
        if (frame_tick && ctrl_q[0]) state_d = ADVANCE;
      end
      ADVANCE: begin
        for (int l = 0; l < 4; l++)
          for (int e = 0; e < 8; e++)
            if (is_active(3'(e), head_q[l], cnt_q[l]))
              mem_d[l][e] = sat_add(mem_q[l][e], ctrl_q[7:4]);
        state_d = RETIRE;
      end
      RETIRE: begin
        // Queues are age-ordered, so every note past the bottom sits at the head end.
        for (int l = 0; l < 4; l++) begin
          logic [3:0] n;
          n = 4'd0;
          for (int e = 0; e < 8; e++)
            if (is_active(3'(e), head_q[l], cnt_q[l]) && mem_q[l][e] >= BOTTOM)
              n = n + 4'd1;
          head_d[l] = head_q[l] + n[2:0];
          cnt_d[l]  = cnt_q[l] - n;
          miss_add  = miss_add + {2'd0, n};
        end
        miss_sum = {1'b0, miss_q} + {11'd0, miss_add};
        miss_d   = miss_sum[16] ? 16'hffff : miss_sum[15:0];
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && wr_en && (addr[1:0] == 2'd1 || addr[1:0] == 2'd2)) begin
      pend_v_d    = 1'b1;
      pend_hit_d  = addr[1];
      pend_lane_d = wr_data[1:0];
    end

    if (op_v) begin
      if (!op_hit) begin
        if (cnt_q[op_lane] != 4'd8) begin
          mem_d[op_lane][tail_q[op_lane]] = 9'd0;
          tail_d[op_lane] = tail_q[op_lane] + 3'd1;
          cnt_d[op_lane]  = cnt_q[op_lane] + 4'd1;
        end
      end else if (cnt_q[op_lane] != 4'd0 &&
                   mem_q[op_lane][head_q[op_lane]] >= HIT_LO &&
                   mem_q[op_lane][head_q[op_lane]] <= HIT_HI) begin
        head_d[op_lane] = head_q[op_lane] + 3'd1;
        cnt_d[op_lane]  = cnt_q[op_lane] - 4'd1;
        hit_d           = (hit_q == 16'hffff) ? hit_q : hit_q + 16'd1;
      end
    end

    if (wr_en && addr[1:0] == 2'd3) begin
      for (int l = 0; l < 4; l++) begin
        head_d[l] = 3'd0;
        tail_d[l] = 3'd0;
        cnt_d[l]  = 4'd0;
      end
      hit_d    = 16'd0;
      miss_d   = 16'd0;
      pend_v_d = 1'b0;
      state_d  = IDLE;
    end
  end

  always_comb begin
    note_hit = 1'b0;
    note_col = '0;
    for (int l = 0; l < 4; l++)
      if (x >= 11'(LANE_X0 + l * LANE_W + 4) && x < 11'(LANE_X0 + (l + 1) * LANE_W - 4))
        for (int e = 0; e < 8; e++)
          if (is_active(3'(e), head_q[l], cnt_q[l]) && y >= {2'd0, mem_q[l][e]} &&
              y < {2'd0, mem_q[l][e]} + 11'(NOTE_H)) begin
            note_hit = 1'b1;
            note_col = COLORS[l];
          end
    on_line  = (y == LINE_Y) && (x >= LINE_XL) && (x < LINE_XH);
    so_rgb_d = si_rgb;
    if (ctrl_q[0]) begin
      if (note_hit)     so_rgb_d = note_col;
      else if (on_line) so_rgb_d = {CD{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ctrl_q      <= 8'd0;
      pend_v_q    <= 1'b0;
      pend_hit_q  <= 1'b0;
      pend_lane_q <= 2'd0;
      hit_q       <= 16'd0;
      miss_q      <= 16'd0;
      origin_q    <= 1'b0;
      so_rgb_q    <= '0;
      for (int l = 0; l < 4; l++) begin
        head_q[l] <= 3'd0;
        tail_q[l] <= 3'd0;
        cnt_q[l]  <= 4'd0;
        for (int e = 0; e < 8; e++) mem_q[l][e] <= 9'd0;
      end
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      pend_v_q    <= pend_v_d;
      pend_hit_q  <= pend_hit_d;
      pend_lane_q <= pend_lane_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      origin_q    <= (x == 11'd0) && (y == 11'd0);
      so_rgb_q    <= so_rgb_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign so_rgb     = so_rgb_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_chu_vga_note_lane_core.sv
// Directed bench for chu_vga_note_lane_core: bus writes, synthetic frame starts
// and pixel probes, each checked against hand-computed values.
module tb_chu_vga_note_lane_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [11:0] si_rgb, so_rgb;
  logic [15:0] hit_count, miss_count;

  int tests_run = 0;
  int tests_failed = 0;

  chu_vga_note_lane_core dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = {12'd0, a}; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // at_clk: 0 = tick clk, 1 = ADVANCE clk, 2 = RETIRE clk
  task automatic run_frame(input bit do_wr, input int at_clk, input logic [1:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    x = 11'd1; y = 11'd1;
    @(negedge clk);
    x = 11'd0; y = 11'd0;
    for (int k = 0; k < 5; k++) begin
      cs = do_wr && (k == at_clk);
      write = cs; addr = {12'd0, a}; wr_data = d;
      @(negedge clk);
    end
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) run_frame(1'b0, 0, 2'd0, 32'd0);
  endtask

  task automatic probe(input string tag, input int px, input int py,
                       input logic [11:0] si, input logic [11:0] exp);
    @(negedge clk);
    x = 11'(px); y = 11'(py); si_rgb = si;
    @(posedge clk);
    #1;
    check_val(tag, {20'd0, so_rgb}, {20'd0, exp});
  endtask

  initial begin
    reset_n = 1'b0; x = 11'd5; y = 11'd5; cs = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; si_rgb = 12'habc;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset so_rgb", {20'd0, so_rgb}, 32'h0);
    check_val("reset hit", {16'd0, hit_count}, 32'h0);
    check_val("reset miss", {16'd0, miss_count}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Disabled: passthrough, notes frozen
    probe("dis passthru", 200, 428, 12'h123, 12'h123);
    bus_wr(2'd1, 32'd0);
    frames(5);
    bus_wr(2'd0, 32'h01);
    probe("dis frozen top", 164, 0, 12'h050, 12'hf00);
    probe("dis frozen below", 164, 16, 12'h050, 12'h050);
    probe("hit line", 200, 428, 12'h050, 12'hfff);
    probe("hit line right edge", 480, 428, 12'h050, 12'h050);
    bus_wr(2'd3, 32'd0);
    probe("clear lane0", 164, 0, 12'h050, 12'h050);

    // Speed 1, 100 frames -> y=100
    bus_wr(2'd0, 32'h11);
    bus_wr(2'd1, 32'd0);
    frames(100);
    probe("y100 top", 164, 100, 12'h001, 12'hf00);
    probe("y100 above", 164, 99, 12'h001, 12'h001);
    probe("y100 bottom", 164, 115, 12'h001, 12'hf00);
    probe("y100 past", 164, 116, 12'h001, 12'h001);
    probe("lane0 left", 163, 100, 12'h001, 12'h001);
    probe("lane0 right in", 235, 100, 12'h001, 12'hf00);
    probe("lane0 right out", 236, 100, 12'h001, 12'h001);
    bus_wr(2'd3, 32'd0);

    // Speed 15, two notes retire together
    bus_wr(2'd0, 32'hF1);
    bus_wr(2'd1, 32'd2);
    bus_wr(2'd1, 32'd2);
    frames(31);
    check_val("miss before 480", {16'd0, miss_count}, 32'd0);
    probe("lane2 y465", 330, 465, 12'h002, 12'h00f);
    frames(1);
    check_val("miss pair", {16'd0, miss_count}, 32'd2);
    probe("lane2 gone", 330, 480, 12'h002, 12'h002);
    bus_wr(2'd3, 32'd0);

    // Fill lane 1, ninth push dropped, wrap
    bus_wr(2'd0, 32'h01);
    for (int i = 0; i < 9; i++) bus_wr(2'd1, 32'd1);
    bus_wr(2'd0, 32'hF1);
    frames(32);
    check_val("miss full lane", {16'd0, miss_count}, 32'd8);
    bus_wr(2'd1, 32'd1);
    probe("lane1 after wrap", 250, 5, 12'h003, 12'h0f0);
    frames(32);
    check_val("miss after wrap", {16'd0, miss_count}, 32'd9);
    bus_wr(2'd3, 32'd0);

    // Hit inside and outside window
    bus_wr(2'd0, 32'hA1);
    bus_wr(2'd1, 32'd3);
    frames(41);
    bus_wr(2'd2, 32'd3);
    check_val("hit y410", {16'd0, hit_count}, 32'd1);
    probe("lane3 emptied", 420, 410, 12'h004, 12'h004);
    bus_wr(2'd1, 32'd3);
    frames(30);
    bus_wr(2'd2, 32'd3);
    check_val("hit y300 none", {16'd0, hit_count}, 32'd1);
    probe("lane3 y300 kept", 420, 300, 12'h004, 12'hff0);
    bus_wr(2'd3, 32'd0);
    check_val("clear hit", {16'd0, hit_count}, 32'd0);

    // Window edges and deferred HIT during ADVANCE
    bus_wr(2'd0, 32'h11);
    bus_wr(2'd1, 32'd3);
    frames(403);
    bus_wr(2'd2, 32'd3);
    check_val("hit y403 none", {16'd0, hit_count}, 32'd0);
    run_frame(1'b1, 1, 2'd2, 32'd3);
    check_val("pending hit y404", {16'd0, hit_count}, 32'd1);
    probe("lane3 after pend", 420, 404, 12'h005, 12'h005);
    bus_wr(2'd0, 32'hF1);
    bus_wr(2'd1, 32'd3);
    frames(29);
    bus_wr(2'd0, 32'h11);
    frames(1);
    bus_wr(2'd2, 32'd3);
    check_val("hit y436", {16'd0, hit_count}, 32'd2);
    bus_wr(2'd0, 32'hF1);
    bus_wr(2'd1, 32'd3);
    frames(29);
    bus_wr(2'd0, 32'h21);
    frames(1);
    bus_wr(2'd2, 32'd3);
    check_val("hit y437 none", {16'd0, hit_count}, 32'd2);
    probe("lane3 y437 kept", 420, 437, 12'h006, 12'hff0);

    // CLEAR during RETIRE
    run_frame(1'b1, 2, 2'd3, 32'd0);
    check_val("clr retire hit", {16'd0, hit_count}, 32'd0);
    check_val("clr retire miss", {16'd0, miss_count}, 32'd0);
    probe("clr retire lane3", 420, 439, 12'h007, 12'h007);
    bus_wr(2'd0, 32'h51);
    bus_wr(2'd1, 32'd0);
    frames(1);
    probe("post clr moved", 164, 5, 12'h007, 12'hf00);
    probe("post clr above", 164, 4, 12'h007, 12'h007);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
